// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared register-file widths and the write-back FIFO entry record.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int REG_ID_W = 5;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [REG_ID_W-1:0] rd_id;
        logic [XLEN-1:0]     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ID_W-1:0] id);
        logic [NUM_REGS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_fifo                                                              |
// | Synchronous FIFO holding long-latency write-back entries.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign full  = (count_q == c_full_count);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter                                                           |
// | Merges pipeline and buffered long-latency results onto the register  |
// | file write port; tracks outstanding long-latency writes.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DWIDTH       = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_valid,
    output logic                p_ready,
    input  logic [REG_ID_W-1:0] p_rd_id,
    input  logic [DWIDTH-1:0]   p_data,
    input  logic                l_valid,
    output logic                l_ready,
    input  logic [REG_ID_W-1:0] l_rd_id,
    input  logic [DWIDTH-1:0]   l_data,
    input  logic                issue_valid,
    input  logic [REG_ID_W-1:0] issue_rd_id,
    output logic                we,
    output logic [REG_ID_W-1:0] rdst_id,
    output logic [DWIDTH-1:0]   rdst,
    output logic [NUM_REGS-1:0] busy
);

    localparam int ENTRY_W = REG_ID_W + DWIDTH;
    localparam int AGE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] c_starve_age = AGE_W'(STARVE_LIMIT);

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [REG_ID_W-1:0] head_rd_id;
    logic [DWIDTH-1:0]   head_data;

    logic                starve, sel_pipe;
    logic [AGE_W-1:0]    age_q, age_d;
    logic                we_q, we_d;
    logic [REG_ID_W-1:0] rdst_id_q, rdst_id_d;
    logic [DWIDTH-1:0]   rdst_q, rdst_d;
    logic [NUM_REGS-1:0] busy_q, busy_d, busy_set, busy_clr;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({l_rd_id, l_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign head_rd_id = fifo_head[ENTRY_W-1:DWIDTH];
    assign head_data  = fifo_head[DWIDTH-1:0];

    always_comb begin
        starve    = (age_q == c_starve_age);
        sel_pipe  = p_valid && !starve;
        fifo_pop  = !sel_pipe && !fifo_empty;
        fifo_push = l_valid && !fifo_full;

        // Age measures how long the current head has been passed over
        age_d = age_q;
        if (fifo_pop || fifo_empty) begin
            age_d = '0;
        end else if (!starve) begin
            age_d = age_q + AGE_W'(1);
        end

        we_d      = 1'b0;
        rdst_id_d = rdst_id_q;
        rdst_d    = rdst_q;
        if (sel_pipe) begin
            we_d      = (p_rd_id != '0);
            rdst_id_d = p_rd_id;
            rdst_d    = p_data;
        end else if (fifo_pop) begin
            we_d      = (head_rd_id != '0);
            rdst_id_d = head_rd_id;
            rdst_d    = head_data;
        end

        busy_set = '0;
        busy_clr = '0;
        if (issue_valid && issue_rd_id != '0) begin
            busy_set = reg_onehot(issue_rd_id);
        end
        if (fifo_pop && head_rd_id != '0) begin
            busy_clr = reg_onehot(head_rd_id);
        end
        // A re-issue landing on the retiring register keeps it busy
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q     <= '0;
            we_q      <= 1'b0;
            rdst_id_q <= '0;
            rdst_q    <= '0;
            busy_q    <= '0;
        end else begin
            age_q     <= age_d;
            we_q      <= we_d;
            rdst_id_q <= rdst_id_d;
            rdst_q    <= rdst_d;
            busy_q    <= busy_d;
        end
    end

    assign p_ready = !starve;
    assign l_ready = !fifo_full;
    assign we      = we_q;
    assign rdst_id = rdst_id_q;
    assign rdst    = rdst_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_arbiter                                                        |
// | Directed scenarios plus random traffic against a queue-based model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wb_arbiter;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int L = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_valid, p_ready, l_valid, l_ready, issue_valid, we;
    logic [4:0]    p_rd_id, l_rd_id, issue_rd_id, rdst_id;
    logic [DW-1:0] p_data, l_data, rdst;
    logic [31:0]   busy;

    always #5 clk = ~clk;

    wb_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(L)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_ready(p_ready), .p_rd_id(p_rd_id), .p_data(p_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd_id(l_rd_id), .l_data(l_data),
        .issue_valid(issue_valid), .issue_rd_id(issue_rd_id),
        .we(we), .rdst_id(rdst_id), .rdst(rdst), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive values for the coming cycle
    logic          d_p_valid, d_l_valid, d_issue;
    logic [4:0]    d_p_rd, d_l_rd, d_issue_rd;
    logic [DW-1:0] d_p_data, d_l_data;

    // Reference model: a queue of entries and the cycle each head arrived
    wb_entry_t   m_q[$];
    int          cyc = 0;
    int          head_since = 0;
    logic        m_we;
    logic [4:0]  m_id;
    logic [31:0] m_data, m_busy;
    bit          m_p_stalled, m_l_pushed;

    int          w_cyc[$];
    logic [4:0]  w_rd[$];
    logic [31:0] w_data[$];
    int          pready_low, low_cyc;
    logic [4:0]  oq[$];

    function automatic bit m_starve();
        return (m_q.size() > 0) && ((cyc - head_since) >= L);
    endfunction

    task automatic clear_drive();
        d_p_valid = 0; d_p_rd = 0; d_p_data = 0;
        d_l_valid = 0; d_l_rd = 0; d_l_data = 0;
        d_issue = 0; d_issue_rd = 0;
    endtask

    task automatic apply_drive();
        p_valid = d_p_valid; p_rd_id = d_p_rd; p_data = d_p_data;
        l_valid = d_l_valid; l_rd_id = d_l_rd; l_data = d_l_data;
        issue_valid = d_issue; issue_rd_id = d_issue_rd;
    endtask

    task automatic model_reset();
        m_q.delete(); oq.delete();
        m_we = 0; m_id = 0; m_data = 0; m_busy = 0;
        m_p_stalled = 0; m_l_pushed = 0;
    endtask

    task automatic clear_log();
        w_cyc.delete(); w_rd.delete(); w_data.delete();
        pready_low = 0; low_cyc = -1;
    endtask

    task automatic model_update();
        bit st, sel_p, pop, push;
        int pre_size;
        wb_entry_t h, e;
        pre_size = m_q.size();
        st    = m_starve();
        sel_p = d_p_valid && !st;
        pop   = !sel_p && (pre_size > 0);
        push  = d_l_valid && (pre_size < DEPTH);
        m_p_stalled = d_p_valid && st;
        m_l_pushed  = push;
        if (sel_p) begin
            m_we = (d_p_rd != 0); m_id = d_p_rd; m_data = d_p_data;
        end else if (pop) begin
            h = m_q.pop_front();
            m_we = (h.rd_id != 0); m_id = h.rd_id; m_data = h.data;
            if (h.rd_id != 0) m_busy[h.rd_id] = 1'b0;
        end else begin
            m_we = 0;
        end
        if (d_issue && d_issue_rd != 0) m_busy[d_issue_rd] = 1'b1;
        if (pop || pre_size == 0) head_since = cyc + 1;
        if (push) begin
            e.rd_id = d_l_rd; e.data = d_l_data;
            m_q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_value("we", we, m_we);
        if (m_we) begin
            check_value("rdst_id", rdst_id, m_id);
            check_value("rdst", rdst, m_data);
        end
        check_value("busy", busy, m_busy);
        if (we) begin
            w_cyc.push_back(cyc); w_rd.push_back(rdst_id); w_data.push_back(rdst);
        end
        apply_drive();
        #1;
        check_value("p_ready", p_ready, !m_starve());
        check_value("l_ready", l_ready, m_q.size() < DEPTH);
        if (!p_ready) begin
            pready_low++;
            if (low_cyc < 0) low_cyc = cyc;
        end
        model_update();
        cyc++;
    endtask

    task automatic do_reset();
        clear_drive(); apply_drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_we", we, 0);
        check_value("rst_rdst_id", rdst_id, 0);
        check_value("rst_rdst", rdst, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_l_ready", l_ready, 1);
        check_value("rst_p_ready", p_ready, 1);
        rst = 1'b0;
        model_reset();
        clear_log();
    endtask

    task automatic issue_one(input logic [4:0] rd);
        clear_drive(); d_issue = 1; d_issue_rd = rd; step(); clear_drive();
    endtask

    initial begin
        int k, push_cyc, n_l;
        logic [4:0] rd;
        rst = 1'b0;
        model_reset(); clear_log();

        // Priority then FIFO drain
        do_reset();
        d_p_valid = 1; d_p_rd = 5; d_p_data = 32'h11;
        d_l_valid = 1; d_l_rd = 6; d_l_data = 32'h22;
        step(); clear_drive();
        repeat (4) step();
        check_value("prio_nwrites", w_rd.size(), 2);
        if (w_rd.size() == 2) begin
            check_value("prio_rd0", w_rd[0], 5);
            check_value("prio_d0", w_data[0], 32'h11);
            check_value("prio_rd1", w_rd[1], 6);
            check_value("prio_d1", w_data[1], 32'h22);
            check_value("prio_gap", w_cyc[1] - w_cyc[0], 1);
        end

        // Fill and backpressure under constant pipeline traffic
        do_reset();
        for (int i = 0; i < 5; i++) issue_one(5'(10 + i));
        clear_log();
        k = 0;
        for (int i = 0; i < 80; i++) begin
            d_p_valid = 1; d_p_rd = 1; d_p_data = 32'h55;
            d_l_valid = (k < 5); d_l_rd = 5'(10 + k); d_l_data = 32'hA0 + k;
            step();
            if (m_l_pushed) k++;
        end
        clear_drive();
        repeat (10) step();
        n_l = 0;
        for (int i = 0; i < w_rd.size(); i++) begin
            if (w_rd[i] >= 10) begin
                check_value("fill_order_rd", w_rd[i], 10 + n_l);
                check_value("fill_order_d", w_data[i], 32'hA0 + n_l);
                n_l++;
            end
        end
        check_value("fill_count", n_l, 5);

        // Starvation of a single head entry
        do_reset();
        issue_one(9);
        d_p_valid = 1; d_p_rd = 2; d_p_data = 32'h33;
        step();
        clear_log();
        push_cyc = cyc;
        d_l_valid = 1; d_l_rd = 9; d_l_data = 32'h99;
        step();
        d_l_valid = 0;
        repeat (L + 6) step();
        clear_drive();
        repeat (2) step();
        check_value("starve_low_cycles", pready_low, 1);
        check_value("starve_low_at", low_cyc, push_cyc + 1 + L);
        n_l = 0;
        for (int i = 0; i < w_rd.size(); i++) begin
            if (w_rd[i] == 9) begin
                n_l++;
                check_value("starve_wr_at", w_cyc[i], low_cyc + 1);
            end
        end
        check_value("starve_wr_count", n_l, 1);

        // Scoreboard set-wins on re-issue in the pop cycle
        do_reset();
        issue_one(7);
        #5;
        check_value("sb_busy7_rise", busy[7], 1);
        repeat (2) step();
        d_l_valid = 1; d_l_rd = 7; d_l_data = 32'hAB;
        step(); clear_drive();
        d_issue = 1; d_issue_rd = 7;
        step(); clear_drive();
        step();
        check_value("sb_busy7_held", busy[7], 1);
        check_value("sb_nwrites", w_rd.size(), 1);
        if (w_rd.size() == 1) begin
            check_value("sb_rd", w_rd[0], 7);
            check_value("sb_data", w_data[0], 32'hAB);
        end
        d_l_valid = 1; d_l_rd = 7; d_l_data = 32'hCD;
        step(); clear_drive();
        repeat (3) step();
        check_value("sb_busy_clear", busy, 0);

        // x0 entries are consumed silently
        do_reset();
        d_p_valid = 1; d_p_rd = 0; d_p_data = 32'h77;
        d_l_valid = 1; d_l_rd = 0; d_l_data = 32'h88;
        d_issue = 1; d_issue_rd = 0;
        step(); clear_drive();
        repeat (4) step();
        check_value("x0_nwrites", w_rd.size(), 0);
        check_value("x0_busy", busy, 0);
        check_value("x0_drained", l_ready, 1);

        // Asynchronous reset in the middle of a drain
        do_reset();
        issue_one(3);
        issue_one(4);
        d_p_valid = 1; d_p_rd = 2; d_p_data = 32'h44;
        for (int i = 0; i < 3; i++) begin
            d_l_valid = 1; d_l_rd = (i == 2) ? 5'd0 : 5'(3 + i); d_l_data = 32'hC0 + i;
            step();
        end
        d_l_valid = 0;
        step();
        check_value("ar_busy_pre", busy, 32'h18);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_value("ar_we", we, 0);
        check_value("ar_busy", busy, 0);
        check_value("ar_l_ready", l_ready, 1);
        check_value("ar_p_ready", p_ready, 1);
        clear_drive(); apply_drive();
        rst = 1'b0;
        model_reset(); clear_log();
        repeat (6) step();
        check_value("ar_no_writes", w_rd.size(), 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int pdens;
            pdens = ((i / 250) % 2 == 0) ? 9 : 4;
            if (!m_p_stalled) begin
                d_p_valid = ($urandom_range(0, 9) < pdens);
                d_p_rd = 5'($urandom_range(0, 31));
                d_p_data = $urandom;
            end
            if (m_l_pushed && d_l_rd != 0 && oq.size() > 0) void'(oq.pop_front());
            if (!(d_l_valid && !m_l_pushed)) begin
                d_l_valid = 0;
                if (oq.size() > 0 && $urandom_range(0, 1) == 1) begin
                    d_l_valid = 1; d_l_rd = oq[0]; d_l_data = $urandom;
                end else if ($urandom_range(0, 9) == 0) begin
                    d_l_valid = 1; d_l_rd = 0; d_l_data = $urandom;
                end
            end
            rd = 5'($urandom_range(0, 31));
            d_issue = ($urandom_range(0, 3) == 0) && (rd == 0 || !m_busy[rd]);
            d_issue_rd = rd;
            if (d_issue && rd != 0) oq.push_back(rd);
            step();
        end
        clear_drive();
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter in front of the integer register file's single write port. It merges two result sources onto the `we`/`rdst_id`/`rdst` port. The first source is the in-order pipeline, which has priority. The second is a long-latency unit (load/divide), which is buffered in a small FIFO with a valid/ready handshake. It also keeps a 32-bit pending-write scoreboard, which decode uses to stall on RAW/WAW hazards against outstanding long-latency results.

## Interface
- `DWIDTH`, 32, data width
- `DEPTH`, 4, long-latency FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, cycles a FIFO head may wait before forcing priority (≥1)

- `clk`  in  1  system clock
- `rst`  in  1  system reset, asynchronous, active-high
- `p_valid`  in  1  pipeline result valid
- `p_ready`  out  1  pipeline result accepted this cycle
- `p_rd_id`  in  5  pipeline destination register
- `p_data`  in  DWIDTH  pipeline result
- `l_valid`  in  1  long-latency result valid
- `l_ready`  out  1  FIFO can accept (= not full)
- `l_rd_id`  in  5  long-latency destination register
- `l_data`  in  DWIDTH  long-latency result
- `issue_valid`  in  1  long-latency op issued this cycle
- `issue_rd_id`  in  5  its destination register
- `we`  out  1  register-file write enable
- `rdst_id`  out  5  register-file destination ID
- `rdst`  out  DWIDTH  register-file write data
- `busy`  out  32  scoreboard; bit r = write to r outstanding

## Operation
- **FIFO push:** when `l_valid && l_ready`. `l_ready = (count != DEPTH)`. It is registered-state-derived, with no combinational path from `l_valid`.
- **Head age counter:**
  - Cleared on pop, and while the FIFO is empty.
  - Otherwise increments, saturating at `STARVE_LIMIT`.
  - `starve = (age == STARVE_LIMIT)`.
- **Selection each cycle:**
  - If `!starve && p_valid`: the pipeline wins and `p_ready=1`.
  - Else if the FIFO is non-empty: pop the head.
  - Else: no write.
- **`p_ready`:** equals `!starve`. When `p_ready=0`, upstream holds `p_*` stable.
- **Pop from full FIFO:** `l_ready` stays 0 that cycle. It rises the next cycle.
- **x0:** a selected entry with rd = 0 is consumed (popped or accepted) but produces `we=0`.
- **Scoreboard:**
  - `issue_valid` with rd≠0 sets `busy[rd]`.
  - A pop of an entry with rd≠0 clears `busy[rd]`.
  - Same-cycle set and clear of the same bit: set wins.
  - `busy[0]` is constant 0.
- **Upstream guarantees, unchecked:**
  - No issue to a register whose busy bit is already set.
  - No pipeline write to a busy register.
  - Every issue eventually yields exactly one `l_valid` transfer with the same rd.
- **Pipeline writes** never touch the scoreboard.

## Timing
- **Output latency:** the selection in cycle N appears on `we`/`rdst_id`/`rdst` (registered) in cycle N+1. The register file commits at the end of N+1.
- **Push-to-write:** a push in cycle N is poppable in N+1 at earliest. The write is visible on the port in N+2.
- **Scoreboard clear:** applied at the pop edge, so `busy` falls in the same cycle that `we` rises for that entry.
- **Starvation bound:** with `p_valid` held at 1, a head entry is written at most `STARVE_LIMIT+2` cycles after it reaches the head.
- **Reset (async, any cycle):**
  - Outputs: `we=0`, `rdst_id=0`, `rdst=0`, `busy=0`.
  - State: count/pointers/age = 0.
  - Handshakes: `l_ready=1`, `p_ready=1`.
  - In-flight FIFO contents are discarded.

## Structure
- **Shared package** (`cpu_pkg`): `REG_ID_W=5`, `NUM_REGS=32`, and the FIFO entry record (`rd_id`, `data`).
- **Sub-module** `wb_fifo`: synchronous FIFO parameterised by `DEPTH`/width.
  - Interfaces: push/pop/full/empty/head.
  - Wrap-around via pointer-extra-bit or a count register.
- **Top-level logic:** arbitration, age counter, scoreboard and output register live in `wb_arbiter`.

## Test plan
- **Priority and FIFO drain:**
  - Stimulus: reset; `p_valid=1`, rd=5, data 0x11 in cycle 1; `l_valid=1`, rd=6, data 0x22 in cycle 1; `p_valid=0` afterwards.
  - Response: `we`/rd5/0x11 in cycle 2; rd6/0x22 in cycle 3.
- **Fill and backpressure:**
  - Stimulus: hold `p_valid=1`; push 4 entries; offer a 5th.
  - Response: `l_ready=0` after the 4th push; the 5th is held until `starve` forces a pop; `l_ready` returns the following cycle; no entry lost or reordered.
- **Starvation:**
  - Stimulus: `p_valid=1` continuously; one FIFO entry rd=9.
  - Response: `p_ready=0` for exactly one cycle, `STARVE_LIMIT` cycles after the push+1; the rd9 write follows; then `p_ready=1`.
- **Scoreboard:**
  - Stimulus: issue rd=7; later push rd=7, 0xAB; in the pop cycle, re-issue rd=7.
  - Response: `busy[7]` rises the cycle after the first issue; it stays 1 through the pop (set wins); `we` rd7 0xAB is emitted.
- **x0 handling:**
  - Stimulus: pipeline rd=0 and FIFO rd=0 entries; issue rd=0.
  - Response: `we` never asserts; entries consumed; `busy==0`.
- **Async reset mid-drain:**
  - Stimulus: 3 entries queued, `busy[3]`/`busy[4]` set; pulse `rst` between edges.
  - Response: immediately `we=0`, `busy=0`, `l_ready=1`; no further writes after release.
